// File: rtl/adc_if_pkg.sv
// rtl/adc_if_pkg.sv - shared types and constants for the parallel ADC responder
//
// Purpose : FSM state type, configuration bit positions, bus/counter widths
//           and the test-pattern word generator used by adc_responder.
// Ports   : none (package).
package adc_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READOUT
  } adc_state_e;

  localparam int CFG_PATTERN_BIT = 0;
  localparam int ADC_DATA_W      = 16;
  localparam int CONV_CNT_W      = 12;

  // Test-pattern word: channel index in the top nibble, conversion count below.
  function automatic logic [ADC_DATA_W-1:0] pattern_word(
    input logic [3:0]            ch,
    input logic [CONV_CNT_W-1:0] cnt
  );
    return {ch, cnt};
  endfunction

endpackage

// File: rtl/strobe_edge.sv
// rtl/strobe_edge.sv - one-deep strobe history with rise/fall detection
//
// Purpose : registers a strobe once and flags the cycle in which the sampled
//           value differs from the previous sample.
// Ports   : clk, rst_n (async, active-low), strobe (sampled input),
//           rise (0->1 seen this cycle), fall (1->0 seen this cycle).
module strobe_edge #(
  // Idle level of the strobe, so leaving reset does not fake an edge.
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic rise,
  output logic fall
);

  logic strobe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= RESET_VAL;
    end else begin
      strobe_q <= strobe;
    end
  end

  assign rise = strobe & ~strobe_q;
  assign fall = ~strobe & strobe_q;

endmodule

// File: rtl/adc_responder.sv
// rtl/adc_responder.sv - slave-side emulator of the 16-bit parallel ADC
//
// Purpose : accepts CONVST strobes, holds busy for a fixed conversion time,
//           then serves one captured word per qualified RD_N strobe; accepts
//           configuration writes on WR_N in software mode while idle.
// Ports   : clk, sresetn (async, active-low), hw_n_sw, cs_n, rd_n, wr_n,
//           conv_start[3:0], db_in, sample_in (channel k at [k*DATA_W +: DATA_W]),
//           busy, db_out, db_oe, conv_count[11:0].
module adc_responder
  import adc_if_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = ADC_DATA_W,
  parameter int CONV_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     sresetn,
  input  logic                     hw_n_sw,
  input  logic                     cs_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic [3:0]               conv_start,
  input  logic [DATA_W-1:0]        db_in,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  output logic                     busy,
  output logic [DATA_W-1:0]        db_out,
  output logic                     db_oe,
  output logic [CONV_CNT_W-1:0]    conv_count
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CH - 1);

  adc_state_e          state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [PTR_W-1:0]    ptr;
  logic [7:0]          cfg;
  logic [DATA_W-1:0]   bank [NUM_CH];

  logic conv_rise, conv_fall;
  logic rd_rise, rd_fall;
  logic wr_rise, wr_fall;
  logic rd_edge, wr_edge, cfg_we;
  logic capture, conv_done, rd_serve;

  // Any CONVST bit rising is one event; OR-reducing first merges simultaneous rises.
  strobe_edge #(.RESET_VAL(1'b0)) u_conv_edge (
    .clk    (clk),
    .rst_n  (sresetn),
    .strobe (|conv_start),
    .rise   (conv_rise),
    .fall   (conv_fall)
  );

  strobe_edge #(.RESET_VAL(1'b1)) u_rd_edge (
    .clk    (clk),
    .rst_n  (sresetn),
    .strobe (rd_n),
    .rise   (rd_rise),
    .fall   (rd_fall)
  );

  strobe_edge #(.RESET_VAL(1'b1)) u_wr_edge (
    .clk    (clk),
    .rst_n  (sresetn),
    .strobe (wr_n),
    .rise   (wr_rise),
    .fall   (wr_fall)
  );

  assign rd_edge = rd_fall & ~cs_n;
  assign wr_edge = wr_rise & ~cs_n;
  assign cfg_we  = wr_edge & hw_n_sw & (state == IDLE);

  // Unused edge polarities and reserved configuration bits.
  logic unused_ok;
  assign unused_ok = &{1'b0, conv_fall, rd_rise, wr_fall, cfg[7:1], db_in[DATA_W-1:8]};

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    conv_done  = 1'b0;
    rd_serve   = 1'b0;
    case (state)
      IDLE: begin
        if (conv_rise) begin
          capture    = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt == '0) begin
          conv_done  = 1'b1;
          state_next = READOUT;
        end
      end
      READOUT: begin
        // A new conversion request outranks a read in the same cycle.
        if (conv_rise) begin
          capture    = 1'b1;
          state_next = CONVERT;
        end else if (rd_edge) begin
          rd_serve = 1'b1;
          if (ptr == LAST_PTR) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CONVERT);

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      cnt        <= '0;
      ptr        <= '0;
      cfg        <= '0;
      db_out     <= '0;
      db_oe      <= 1'b0;
      conv_count <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        bank[k] <= '0;
      end
    end else begin
      db_oe <= ~cs_n & ~rd_n;

      if (cfg_we) begin
        cfg <= db_in[7:0];
      end

      // Loaded with one less than the conversion time: the expiry cycle
      // itself is the last busy cycle.
      if (capture) begin
        cnt <= CNT_W'(CONV_CYCLES - 1);
        for (int k = 0; k < NUM_CH; k++) begin
          bank[k] <= cfg[CFG_PATTERN_BIT] ? DATA_W'(pattern_word(4'(k), conv_count))
                                          : sample_in[k*DATA_W +: DATA_W];
        end
      end else if (state == CONVERT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (conv_done) begin
        conv_count <= conv_count + CONV_CNT_W'(1);
        ptr        <= '0;
      end

      if (rd_serve) begin
        db_out <= bank[ptr];
        ptr    <= (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// tb/tb_adc_responder.sv - directed/randomized self-checking bench for adc_responder
module tb_adc_responder;

  localparam int NUM_CH = 8;
  localparam int DW     = 16;
  localparam int CONV   = 15;

  logic                   clk;
  logic                   sresetn;
  logic                   hw_n_sw;
  logic                   cs_n;
  logic                   rd_n;
  logic                   wr_n;
  logic [3:0]             conv_start;
  logic [DW-1:0]          db_in;
  logic [NUM_CH*DW-1:0]   sample_in;
  logic                   busy;
  logic [DW-1:0]          db_out;
  logic                   db_oe;
  logic [11:0]            conv_count;

  adc_responder #(.NUM_CH(NUM_CH), .DATA_W(DW), .CONV_CYCLES(CONV)) dut (
    .clk        (clk),
    .sresetn    (sresetn),
    .hw_n_sw    (hw_n_sw),
    .cs_n       (cs_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .conv_start (conv_start),
    .db_in      (db_in),
    .sample_in  (sample_in),
    .busy       (busy),
    .db_out     (db_out),
    .db_oe      (db_oe),
    .conv_count (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: what an ADC of this kind would hand out, independent of RTL.
  int            exp_count;
  logic [7:0]    exp_cfg;
  logic [DW-1:0] last_db;
  logic [DW-1:0] pending [$];
  logic [DW-1:0] samples [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_samples();
    for (int k = 0; k < NUM_CH; k++) sample_in[k*DW +: DW] = samples[k];
  endtask

  task automatic random_samples();
    for (int k = 0; k < NUM_CH; k++) samples[k] = 16'($urandom);
    apply_samples();
  endtask

  // A new conversion replaces whatever was still unread.
  task automatic model_capture();
    pending.delete();
    for (int k = 0; k < NUM_CH; k++) begin
      if (exp_cfg[0]) pending.push_back(16'((k * 4096) + exp_count));
      else            pending.push_back(samples[k]);
    end
  endtask

  task automatic model_reset();
    pending.delete();
    exp_count = 0;
    exp_cfg   = 8'h00;
    last_db   = '0;
  endtask

  task automatic do_conversion(input logic [3:0] mask);
    int width;
    model_capture();
    conv_start = mask;
    @(negedge clk);
    check("busy_rise", {31'd0, busy}, 32'd1);
    conv_start = 4'h0;
    width = 1;
    while (busy === 1'b1 && width < 100) begin
      @(negedge clk);
      if (busy === 1'b1) width++;
    end
    check("busy_width", width, CONV);
    exp_count = (exp_count + 1) % 4096;
    check("conv_count", {20'd0, conv_count}, exp_count);
  endtask

  task automatic read_word(input string tag);
    cs_n = 1'b0;
    rd_n = 1'b0;
    @(negedge clk);
    if (pending.size() > 0) last_db = pending.pop_front();
    check(tag, {16'd0, db_out}, {16'd0, last_db});
    check("db_oe_read", {31'd0, db_oe}, 32'd1);
    rd_n = 1'b1;
    cs_n = 1'b1;
    @(negedge clk);
    check("db_oe_idle", {31'd0, db_oe}, 32'd0);
  endtask

  // The model is idle exactly when no words are owed to the master.
  task automatic write_cfg(input logic mode, input logic [DW-1:0] val);
    hw_n_sw = mode;
    db_in   = val;
    cs_n    = 1'b0;
    wr_n    = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b1;
    if (mode && pending.size() == 0) exp_cfg = val[7:0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]    mask;
    logic [DW-1:0] keep;
    int            width;

    sresetn    = 1'b0;
    hw_n_sw    = 1'b0;
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    conv_start = 4'h0;
    db_in      = '0;
    sample_in  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_dbout", {16'd0, db_out}, 32'd0);
    check("rst_dboe",  {31'd0, db_oe}, 32'd0);
    check("rst_count", {20'd0, conv_count}, 32'd0);
    sresetn = 1'b1;
    @(negedge clk);

    // All four CONVST bits at once, channel 0 fixed.
    random_samples();
    samples[0] = 16'h1234;
    apply_samples();
    do_conversion(4'hF);
    for (int i = 0; i < NUM_CH; i++) read_word("t1_read");
    read_word("t1_hold");

    // Ramp of known values; ninth read must hold the last word.
    for (int k = 0; k < NUM_CH; k++) samples[k] = 16'(16'h0100 + k);
    apply_samples();
    do_conversion(4'h1);
    for (int i = 0; i < NUM_CH; i++) read_word("t2_read");
    read_word("t2_hold");
    check("t2_last", {16'd0, db_out}, 32'h0107);

    // Hardware-mode write is ignored: live samples still served.
    write_cfg(1'b0, 16'h0001);
    random_samples();
    do_conversion(4'h2);
    for (int i = 0; i < NUM_CH; i++) read_word("t3_live");

    while (exp_count < 5) begin
      random_samples();
      mask = 4'($urandom_range(1, 15));
      do_conversion(mask);
      for (int i = 0; i < NUM_CH; i++) read_word("t3_rand");
    end

    // Software-mode write enables the test pattern at conv_count=5.
    write_cfg(1'b1, 16'h0001);
    random_samples();
    do_conversion(4'h8);
    for (int i = 0; i < 2; i++) read_word("t4_pat");
    write_cfg(1'b1, 16'h0000);
    for (int i = 2; i < NUM_CH; i++) read_word("t4_pat");
    random_samples();
    do_conversion(4'h4);
    for (int i = 0; i < NUM_CH; i++) read_word("t4_pat2");
    write_cfg(1'b1, 16'h0000);

    // Abort after three reads; the new bank is served from channel 0.
    random_samples();
    do_conversion(4'h3);
    for (int i = 0; i < 3; i++) read_word("t5_pre");
    random_samples();
    do_conversion(4'h4);
    for (int i = 0; i < NUM_CH; i++) read_word("t5_post");
    read_word("t5_hold");

    // Reads and a second CONVST while busy change nothing.
    random_samples();
    model_capture();
    keep       = last_db;
    mask       = 4'($urandom_range(1, 15));
    conv_start = mask;
    width      = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      width++;
      case (c)
        0: conv_start = 4'h0;
        1: begin cs_n = 1'b0; rd_n = 1'b0; end
        2: begin check("t6_oe_busy", {31'd0, db_oe}, 32'd1); rd_n = 1'b1; cs_n = 1'b1; end
        4: conv_start = 4'h6;
        5: conv_start = 4'h0;
        7: begin cs_n = 1'b0; rd_n = 1'b0; end
        8: begin rd_n = 1'b1; cs_n = 1'b1; end
        default: ;
      endcase
    end
    check("t6_width", width, CONV);
    check("t6_dbout", {16'd0, db_out}, {16'd0, keep});
    exp_count = (exp_count + 1) % 4096;
    check("t6_count", {20'd0, conv_count}, exp_count);
    for (int i = 0; i < NUM_CH; i++) read_word("t6_read");

    // Reset pulse in the middle of a conversion.
    random_samples();
    model_capture();
    conv_start = 4'h5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) conv_start = 4'h0;
      if (c == 1) begin cs_n = 1'b0; rd_n = 1'b0; end
    end
    check("t7_busy_pre", {31'd0, busy}, 32'd1);
    check("t7_oe_pre", {31'd0, db_oe}, 32'd1);
    sresetn = 1'b0;
    #1;
    model_reset();
    check("t7_busy",  {31'd0, busy}, 32'd0);
    check("t7_dboe",  {31'd0, db_oe}, 32'd0);
    check("t7_count", {20'd0, conv_count}, 32'd0);
    check("t7_dbout", {16'd0, db_out}, 32'd0);
    @(negedge clk);
    rd_n    = 1'b1;
    cs_n    = 1'b1;
    sresetn = 1'b1;
    @(negedge clk);
    read_word("t7_idle_read");
    random_samples();
    do_conversion(4'hA);
    for (int i = 0; i < NUM_CH; i++) read_word("t7_read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
